// File: rtl/datapath_core_if.sv
// Memory-side handshake of the datapath core: request/write-enable/address/data out, ack/read data back.
// The core is the master; the memory subsystem is the slave.
interface datapath_core_if #(
    parameter int WIDTH = 32
) ();
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/datapath_core.sv
// Single-bus Mini SRC datapath: GPRs, HI/LO/PC/Y/Z/MAR/MDR on one OR-bus plus a memory-transfer FSM.
// Latency: bus is combinational, loads take one edge; mem_req rises the cycle after mem_read/mem_write.
// Backpressure: memory stalls by withholding mem_ack; the request is abandoned after MEM_TIMEOUT wait cycles.
module datapath_core #(
    parameter int WIDTH       = 32,
    parameter int NUM_REGS    = 16,
    parameter int R0_ZERO     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [NUM_REGS-1:0]  reg_in_sel,
    input  logic [NUM_REGS-1:0]  reg_out_sel,
    input  logic                 HIin,
    input  logic                 LOin,
    input  logic                 PCin,
    input  logic                 Yin,
    input  logic                 Zin,
    input  logic                 MARin,
    input  logic                 MDRin,
    input  logic                 HIout,
    input  logic                 LOout,
    input  logic                 PCout,
    input  logic                 Zhighout,
    input  logic                 Zlowout,
    input  logic                 MDRout,
    input  logic                 InPortout,
    input  logic                 Cout,
    input  logic                 pc_inc,
    input  logic [WIDTH-1:0]     inport_data,
    input  logic [WIDTH-1:0]     c_sign_ext,
    input  logic [2*WIDTH-1:0]   alu_result,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [WIDTH-1:0]     bus,
    output logic                 bus_conflict,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 busy,
    output logic                 mem_done,
    output logic                 timeout_err,
    datapath_core_if.master      mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    logic [WIDTH-1:0]   gpr [NUM_REGS];
    logic [WIDTH-1:0]   hi, lo, pc, y, mar, mdr;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   bus_dat;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       done_nxt;
    logic       err_set;
    logic       rd_load;

    // Wired-OR bus: overlapping selects merge rather than pick a winner, and are flagged.
    always_comb begin
        bus_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_out_sel[i] && !(i == 0 && R0_ZERO != 0))
                bus_dat = bus_dat | gpr[i];
        end
        if (HIout)     bus_dat = bus_dat | hi;
        if (LOout)     bus_dat = bus_dat | lo;
        if (PCout)     bus_dat = bus_dat | pc;
        if (Zhighout)  bus_dat = bus_dat | z[2*WIDTH-1:WIDTH];
        if (Zlowout)   bus_dat = bus_dat | z[WIDTH-1:0];
        if (MDRout)    bus_dat = bus_dat | mdr;
        if (InPortout) bus_dat = bus_dat | inport_data;
        if (Cout)      bus_dat = bus_dat | c_sign_ext;
    end

    assign bus          = bus_dat;
    assign bus_conflict = $countones({reg_out_sel, HIout, LOout, PCout, Zhighout,
                                      Zlowout, MDRout, InPortout, Cout}) > 1;
    assign alu_a        = y;
    assign alu_b        = bus_dat;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_in_sel[i] && !(i == 0 && R0_ZERO != 0))
                    gpr[i] <= bus_dat;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            y   <= '0;
            z   <= '0;
            mar <= '0;
        end else begin
            if (HIin)  hi  <= bus_dat;
            if (LOin)  lo  <= bus_dat;
            if (Yin)   y   <= bus_dat;
            if (Zin)   z   <= alu_result;
            if (MARin) mar <= bus_dat;
            if (PCin)        pc <= bus_dat;
            else if (pc_inc) pc <= pc + 1'b1;
        end
    end

    // Memory owns MDR while a read is outstanding; the bus may still update it during a write.
    assign rd_load = (state == RD_WAIT) && mem.mem_ack;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)                            mdr <= '0;
        else if (rd_load)                      mdr <= mem.mem_rdata;
        else if (MDRin && state != RD_WAIT)    mdr <= bus_dat;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = '0;
                end else if (mem_write) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem.mem_ack) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt == 8'(MEM_TIMEOUT)) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_done <= done_nxt;
            if (err_set) timeout_err <= 1'b1;
        end
    end

    // Request is decoded straight from state so a reset drops it without waiting for an edge.
    assign mem.mem_req   = (state != IDLE);
    assign mem.mem_we    = (state == WR_WAIT);
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = mdr;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_datapath_core.sv
// Bench for datapath_core: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the datapath and memory handshake.
module tb_datapath_core;
    localparam int W    = 32;
    localparam int NR   = 16;
    localparam int TOUT = 15;

    logic clock = 1'b0;
    logic clear;
    logic [NR-1:0] reg_in_sel, reg_out_sel;
    logic HIin, LOin, PCin, Yin, Zin, MARin, MDRin;
    logic HIout, LOout, PCout, Zhighout, Zlowout, MDRout, InPortout, Cout;
    logic pc_inc, mem_read, mem_write;
    logic [W-1:0] inport_data, c_sign_ext;
    logic [2*W-1:0] alu_result;
    logic [W-1:0] alu_a, alu_b, bus;
    logic bus_conflict, busy, mem_done, timeout_err;

    datapath_core_if #(.WIDTH(W)) mif ();

    datapath_core #(.WIDTH(W), .NUM_REGS(NR), .R0_ZERO(1), .MEM_TIMEOUT(TOUT)) dut (
        .clock(clock), .clear(clear),
        .reg_in_sel(reg_in_sel), .reg_out_sel(reg_out_sel),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
        .HIout(HIout), .LOout(LOout), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
        .pc_inc(pc_inc), .inport_data(inport_data), .c_sign_ext(c_sign_ext), .alu_result(alu_result),
        .alu_a(alu_a), .alu_b(alu_b), .bus(bus), .bus_conflict(bus_conflict),
        .mem_read(mem_read), .mem_write(mem_write),
        .busy(busy), .mem_done(mem_done), .timeout_err(timeout_err),
        .mem(mif.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]   m_r [NR];
    logic [W-1:0]   m_hi, m_lo, m_pc, m_y, m_mar, m_mdr;
    logic [2*W-1:0] m_z;
    int             m_op;      // 0 none, 1 read outstanding, 2 write outstanding
    int             m_age;     // wait cycles already spent on the outstanding transfer
    logic           m_done, m_err;
    logic [W-1:0]   m_bus;
    logic           m_conf;

    always_comb begin
        m_bus = '0;
        for (int i = 1; i < NR; i++) if (reg_out_sel[i]) m_bus = m_bus | m_r[i];
        if (HIout)     m_bus = m_bus | m_hi;
        if (LOout)     m_bus = m_bus | m_lo;
        if (PCout)     m_bus = m_bus | m_pc;
        if (Zhighout)  m_bus = m_bus | m_z[2*W-1:W];
        if (Zlowout)   m_bus = m_bus | m_z[W-1:0];
        if (MDRout)    m_bus = m_bus | m_mdr;
        if (InPortout) m_bus = m_bus | inport_data;
        if (Cout)      m_bus = m_bus | c_sign_ext;
        m_conf = ($countones(reg_out_sel) + HIout + LOout + PCout + Zhighout + Zlowout
                  + MDRout + InPortout + Cout) > 1;
    end

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NR; i++) m_r[i] <= '0;
            m_hi <= '0; m_lo <= '0; m_pc <= '0; m_y <= '0; m_mar <= '0; m_mdr <= '0; m_z <= '0;
            m_op <= 0; m_age <= 0; m_done <= 1'b0; m_err <= 1'b0;
        end else begin
            for (int i = 1; i < NR; i++) if (reg_in_sel[i]) m_r[i] <= m_bus;
            if (HIin)  m_hi  <= m_bus;
            if (LOin)  m_lo  <= m_bus;
            if (Yin)   m_y   <= m_bus;
            if (Zin)   m_z   <= alu_result;
            if (MARin) m_mar <= m_bus;
            m_pc <= PCin ? m_bus : (pc_inc ? m_pc + 1 : m_pc);
            if (MDRin && m_op != 1) m_mdr <= m_bus;
            m_done <= 1'b0;
            if (m_op == 0) begin
                if (mem_read)       begin m_op <= 1; m_age <= 0; end
                else if (mem_write) begin m_op <= 2; m_age <= 0; end
            end else if (mif.mem_ack) begin
                m_op <= 0; m_done <= 1'b1;
                if (m_op == 1) m_mdr <= mif.mem_rdata;
            end else if (m_age == TOUT) begin
                m_op <= 0; m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Per-cycle compare, mid low phase after inputs have settled.
    always @(negedge clock) begin
        #3;
        if (chk_en) begin
            chk("bus", bus, m_bus);
            chk("bus_conflict", bus_conflict, m_conf);
            chk("alu_a", alu_a, m_y);
            chk("alu_b", alu_b, m_bus);
            chk("mem_req", mif.mem_req, m_op != 0);
            chk("mem_we", mif.mem_we, m_op == 2);
            chk("mem_addr", mif.mem_addr, m_mar);
            chk("mem_wdata", mif.mem_wdata, m_mdr);
            chk("busy", busy, m_op != 0);
            chk("mem_done", mem_done, m_done);
            chk("timeout_err", timeout_err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic zero_in();
        reg_in_sel = '0; reg_out_sel = '0;
        {HIin, LOin, PCin, Yin, Zin, MARin, MDRin} = '0;
        {HIout, LOout, PCout, Zhighout, Zlowout, MDRout, InPortout, Cout} = '0;
        pc_inc = 0; mem_read = 0; mem_write = 0;
        inport_data = '0; c_sign_ext = '0; alu_result = '0;
        mif.mem_ack = 0; mif.mem_rdata = '0;
    endtask

    task automatic cyc();
        @(negedge clock);
        #1;
        zero_in();
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic randomize_in();
        int r;
        reg_in_sel = ($urandom % 3 == 0) ? NR'(1) << ($urandom % NR) : '0;
        r = $urandom % 8;
        reg_out_sel = '0;
        if (r >= 4) reg_out_sel[$urandom % NR] = 1'b1;
        if (r == 7) reg_out_sel[$urandom % NR] = 1'b1;
        {HIin, LOin, PCin, Yin, Zin, MARin, MDRin} = 7'($urandom) & 7'($urandom) & 7'($urandom);
        {HIout, LOout, PCout, Zhighout} = 4'($urandom) & 4'($urandom) & 4'($urandom);
        {Zlowout, MDRout, InPortout, Cout} = 4'($urandom) & 4'($urandom) & 4'($urandom);
        pc_inc      = ($urandom % 3 == 0);
        mem_read    = ($urandom % 10 == 0);
        mem_write   = ($urandom % 10 == 0);
        inport_data = $urandom;
        c_sign_ext  = $urandom;
        alu_result  = {$urandom, $urandom};
        mif.mem_ack   = ($urandom % 5 == 0);
        mif.mem_rdata = $urandom;
    endtask

    int req_cycles, done_cnt;

    initial begin
        zero_in();
        clear = 1'b0;
        repeat (3) @(negedge clock);
        #4;
        chk("reset bus", bus, 0);
        chk("reset mem_req", mif.mem_req, 0);
        chk("reset busy", busy, 0);
        chk("reset timeout_err", timeout_err, 0);
        chk("reset mem_addr", mif.mem_addr, 0);
        cyc(); clear = 1'b1; chk_en = 1'b1;

        // PC preload, copy into R3, read R3 back
        cyc(); InPortout = 1; inport_data = 32'h1234; PCin = 1;
        cyc(); PCout = 1; reg_in_sel = 16'h0008; settle();
        chk("pc on bus", bus, 32'h1234);
        cyc(); reg_out_sel = 16'h0008; settle();
        chk("r3 bus", bus, 32'h1234);
        chk("r3 conflict", bus_conflict, 0);

        // Hard-zero R0 and wired-OR conflict
        cyc(); InPortout = 1; inport_data = 32'hFFFF; reg_in_sel = 16'h0001;
        cyc(); reg_out_sel = 16'h0001; settle();
        chk("r0 reads zero", bus, 0);
        cyc(); InPortout = 1; inport_data = 32'h0F; reg_in_sel = 16'h0002;
        cyc(); InPortout = 1; inport_data = 32'hF0; reg_in_sel = 16'h0004;
        cyc(); reg_out_sel = 16'h0006; settle();
        chk("r1|r2 bus", bus, 32'hFF);
        chk("r1|r2 conflict", bus_conflict, 1);

        // Read with three wait cycles
        cyc(); InPortout = 1; inport_data = 32'h40; MARin = 1;
        cyc(); mem_read = 1; settle();
        chk("req before start", mif.mem_req, 0);
        cyc(); settle();
        chk("req after strobe", mif.mem_req, 1);
        chk("read addr", mif.mem_addr, 32'h40);
        cyc(); cyc();
        cyc(); mif.mem_ack = 1; mif.mem_rdata = 32'hDEADBEEF;
        cyc(); settle();
        chk("read mdr", mif.mem_wdata, 32'hDEADBEEF);
        chk("read done pulse", mem_done, 1);
        chk("read busy", busy, 0);
        cyc(); settle();
        chk("done single pulse", mem_done, 0);

        // Write with no ack -> timeout
        cyc(); InPortout = 1; inport_data = 32'h55; MDRin = 1;
        cyc(); mem_write = 1;
        req_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(); settle();
            if (mif.mem_req) begin
                req_cycles++;
                chk("write we", mif.mem_we, 1);
            end
        end
        chk("timeout req cycles", req_cycles, TOUT + 1);
        chk("timeout err", timeout_err, 1);
        chk("timeout busy", busy, 0);
        chk("timeout wdata", mif.mem_wdata, 32'h55);

        // Z halves and PC wrap
        cyc(); Zin = 1; alu_result = 64'h00000001_80000000;
        cyc(); Zhighout = 1; settle();
        chk("zhigh bus", bus, 32'h1);
        cyc(); Zlowout = 1; settle();
        chk("zlow bus", bus, 32'h80000000);
        cyc(); InPortout = 1; inport_data = 32'hFFFFFFFF; PCin = 1;
        cyc(); pc_inc = 1;
        cyc(); PCout = 1; settle();
        chk("pc wrap", bus, 0);

        // Reset mid-read
        cyc(); mem_read = 1;
        cyc();
        clear = 1'b0; #1;
        chk("req drops on clear", mif.mem_req, 0);
        #2; clear = 1'b1;
        cyc(); mif.mem_ack = 1; mif.mem_rdata = 32'hCAFEF00D;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(); settle();
            if (mem_done) done_cnt++;
        end
        chk("no done after clear", done_cnt, 0);
        chk("mdr stays zero", mif.mem_wdata, 0);
        chk("err cleared by reset", timeout_err, 0);

        // Ack arrives on the last allowed wait cycle
        cyc(); mem_read = 1;
        for (int k = 0; k < TOUT; k++) cyc();
        cyc(); mif.mem_ack = 1; mif.mem_rdata = 32'h0BADF00D;
        cyc(); settle();
        chk("late ack done", mem_done, 1);
        chk("late ack no err", timeout_err, 0);
        chk("late ack mdr", mif.mem_wdata, 32'h0BADF00D);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            #1;
            randomize_in();
        end
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
